ins_fetch: RTL and testbench

Instruction fetcher directly upstream of the accelerator top's instruction port (ins_valid/ins_ready/ins). On a host start pulse it reads a contiguous instruction stream from DDR in bursts and buffers the returned beats. It unpacks each beat into INST_W-wide instructions and issues them in order over a valid/ready handshake. It signals done once every instruction has been accepted and the accelerator reports idle (working low).

---
 rtl/ins_fetch_pkg.sv | 21 ++
 rtl/ins_beat_fifo.sv | 63 ++++++
 rtl/ins_fetch.sv | 226 ++++++++++++++++++++++
 tb/tb_ins_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// Purpose : shared widths and fetch FSM state type for the instruction fetcher.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: accelerator-wide width constants and the fetch_state_t enum.
package ins_fetch_pkg;

    // Accelerator-wide widths; the fetcher must agree with the accelerator core.
    localparam int G_INST_W     = 64;
    localparam int G_DDR_W      = 512;
    localparam int G_DDR_ADDR_W = 32;
    localparam int G_BURST_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/ins_beat_fifo.sv
// Purpose : synchronous show-ahead FIFO holding DDR read beats for the unpacker.
// Latency : push visible at o_pop_dat one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; o_free exposes free entries.
// Ports   : clk/rst (sync, active-low), i_push/i_push_dat, i_pop/o_pop_dat, o_empty, o_free.
module ins_beat_fifo #(
    parameter int  W     = 512,
    parameter int  DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_dat,
    input  logic             i_pop,
    output logic [W-1:0]     o_pop_dat,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_free
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] one;
        one = PTR_W'(1);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + one;
    endfunction

    assign w_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_free    = CNT_W'(DEPTH) - r_count;

endmodule

// File: rtl/ins_fetch.sv
// Purpose : fetch an instruction stream from DDR in bursts and issue it to the accelerator.
// Latency : first instruction two cycles after its beat is accepted; one instruction per cycle sustained.
// Backpressure: a DDR request is raised only when the beat FIFO can hold the whole burst; ins held while !ins_ready.
// Ports   : host start/start_addr/ins_num -> busy/done; DDR read address + data channels; ins valid/ready; working.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int INST_W          = G_INST_W,
    parameter int DDR_W           = G_DDR_W,
    parameter int DDR_ADDR_W      = G_DDR_ADDR_W,
    parameter int BURST_W         = G_BURST_W,
    parameter int MAX_BURST       = 16,
    parameter int BEAT_FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] start_addr,
    input  logic [15:0]           ins_num,
    output logic                  busy,
    output logic                  done,
    output logic [DDR_ADDR_W-1:0] ddr_addr,
    output logic [BURST_W-1:0]    ddr_size,
    output logic                  ddr_addr_valid,
    input  logic                  ddr_addr_ready,
    input  logic [DDR_W-1:0]      ddr_data,
    input  logic                  ddr_valid,
    output logic                  ddr_ready,
    output logic [INST_W-1:0]     ins,
    output logic                  ins_valid,
    input  logic                  ins_ready,
    input  logic                  working
);
    localparam int IPB        = DDR_W / INST_W;
    localparam int BEAT_BYTES = DDR_W / 8;
    localparam int SLOT_W     = (IPB > 1) ? $clog2(IPB) : 1;
    localparam int BL_W       = $clog2(MAX_BURST + 1);
    localparam int CNT_W      = $clog2(BEAT_FIFO_DEPTH + 1);

    // Request / FSM state
    fetch_state_t          r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [15:0]           r_ins_num;
    logic [15:0]           r_beats_left;
    logic [15:0]           r_total_beats;
    logic [DDR_ADDR_W-1:0] r_cur_addr;
    logic [DDR_ADDR_W-1:0] r_ddr_addr;
    logic [BURST_W-1:0]    r_ddr_size;
    logic                  r_addr_vld;
    logic                  r_ddr_rdy;
    logic [BL_W-1:0]       r_burst_left;

    // Unpacker state
    logic [DDR_W-1:0]      r_beat;
    logic                  r_beat_vld;
    logic [SLOT_W-1:0]     r_slot;
    logic [SLOT_W-1:0]     r_last_slot;
    logic [15:0]           r_pop_cnt;
    logic [15:0]           r_issued;
    logic [INST_W-1:0]     r_ins;
    logic                  r_ins_vld;

    logic                  w_start_acc;
    logic [15:0]           w_start_beats;
    logic [BL_W-1:0]       w_burst;
    logic                  w_space_ok;
    logic                  w_beat_hs;
    logic                  w_ins_hs;
    logic                  w_load;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic [DDR_W-1:0]      w_fifo_dat;
    logic [CNT_W-1:0]      w_free;
    logic [15:0]           w_tail;
    logic                  w_is_final;
    logic [SLOT_W-1:0]     w_next_last;
    logic [INST_W-1:0]     w_slot_dat;

    assign w_start_acc   = (r_state == ST_IDLE) && start;
    assign w_start_beats = 16'((32'(ins_num) + IPB - 1) / IPB);
    assign w_burst       = (r_beats_left > 16'(MAX_BURST)) ? BL_W'(MAX_BURST) : BL_W'(r_beats_left);
    // Space for the whole burst is reserved up front so ddr_ready never drops mid-burst.
    assign w_space_ok    = int'(w_free) >= int'(w_burst);
    assign w_beat_hs     = ddr_valid && r_ddr_rdy;
    assign w_ins_hs      = r_ins_vld && ins_ready;

    // Output register reloads whenever it is empty or being accepted this cycle.
    assign w_load = r_beat_vld && (!r_ins_vld || ins_ready);
    // Next beat is fetched as the last used slot of the current one moves out, so
    // beat boundaries cost no bubble.
    assign w_pop  = !w_fifo_empty && (!r_beat_vld || (w_load && (r_slot == r_last_slot)));

    // The final beat may be partially used; trailing slots beyond ins_num are skipped.
    assign w_tail      = r_ins_num % 16'(IPB);
    assign w_is_final  = (r_pop_cnt == (r_total_beats - 16'd1));
    assign w_next_last = (w_is_final && (w_tail != 16'd0)) ? SLOT_W'(w_tail - 16'd1) : SLOT_W'(IPB - 1);
    assign w_slot_dat  = r_beat[int'(r_slot) * INST_W +: INST_W];

    ins_beat_fifo #(
        .W     (DDR_W),
        .DEPTH (BEAT_FIFO_DEPTH)
    ) u_beat_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_beat_hs),
        .i_push_dat (ddr_data),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_empty    (w_fifo_empty),
        .o_free     (w_free)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ins_num     <= '0;
            r_beats_left  <= '0;
            r_total_beats <= '0;
            r_cur_addr    <= '0;
            r_ddr_addr    <= '0;
            r_ddr_size    <= '0;
            r_addr_vld    <= 1'b0;
            r_ddr_rdy     <= 1'b0;
            r_burst_left  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ins_num     <= ins_num;
                        r_cur_addr    <= start_addr;
                        r_beats_left  <= w_start_beats;
                        r_total_beats <= w_start_beats;
                        r_busy        <= 1'b1;
                        r_state       <= (ins_num == 16'd0) ? ST_FIN : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!r_addr_vld) begin
                        if (w_space_ok) begin
                            r_addr_vld <= 1'b1;
                            r_ddr_addr <= r_cur_addr;
                            r_ddr_size <= BURST_W'(w_burst - BL_W'(1));
                        end
                    end else if (ddr_addr_ready) begin
                        r_addr_vld   <= 1'b0;
                        r_ddr_rdy    <= 1'b1;
                        r_burst_left <= w_burst;
                        r_cur_addr   <= r_cur_addr + DDR_ADDR_W'(w_burst) * DDR_ADDR_W'(BEAT_BYTES);
                        r_beats_left <= r_beats_left - 16'(w_burst);
                        r_state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_hs) begin
                        r_burst_left <= r_burst_left - BL_W'(1);
                        if (r_burst_left == BL_W'(1)) begin
                            r_ddr_rdy <= 1'b0;
                            r_state   <= (r_beats_left != 16'd0) ? ST_REQ : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((r_issued == r_ins_num) && !working) r_state <= ST_FIN;
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat      <= '0;
            r_beat_vld  <= 1'b0;
            r_slot      <= '0;
            r_last_slot <= '0;
            r_pop_cnt   <= '0;
            r_issued    <= '0;
            r_ins       <= '0;
            r_ins_vld   <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_pop_cnt <= '0;
                r_issued  <= '0;
            end else begin
                if (w_pop)    r_pop_cnt <= r_pop_cnt + 16'd1;
                if (w_ins_hs) r_issued  <= r_issued + 16'd1;
            end

            if (w_pop) begin
                r_beat      <= w_fifo_dat;
                r_beat_vld  <= 1'b1;
                r_slot      <= '0;
                r_last_slot <= w_next_last;
            end else if (w_load) begin
                if (r_slot == r_last_slot) r_beat_vld <= 1'b0;
                else                       r_slot     <= r_slot + SLOT_W'(1);
            end

            if (w_load) begin
                r_ins     <= w_slot_dat;
                r_ins_vld <= 1'b1;
            end else if (w_ins_hs) begin
                r_ins_vld <= 1'b0;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign ddr_addr       = r_ddr_addr;
    assign ddr_size       = r_ddr_size;
    assign ddr_addr_valid = r_addr_vld;
    assign ddr_ready      = r_ddr_rdy;
    assign ins            = r_ins;
    assign ins_valid      = r_ins_vld;

endmodule

// File: tb/tb_ins_fetch.sv
// Purpose : directed self-checking bench for ins_fetch with a DDR responder and handshake monitor.
// Latency : n/a.
// Backpressure: DDR address channel delays ready one cycle; ins_ready driven per scenario.
module tb_ins_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  start_addr;
    logic [15:0]  ins_num;
    logic         busy;
    logic         done;
    logic [31:0]  ddr_addr;
    logic [7:0]   ddr_size;
    logic         ddr_addr_valid;
    logic         ddr_addr_ready;
    logic [511:0] ddr_data;
    logic         ddr_valid;
    logic         ddr_ready;
    logic [63:0]  ins;
    logic         ins_valid;
    logic         ins_ready;
    logic         working;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor-owned logs and counters
    logic [63:0] ins_log [$];
    logic [39:0] req_log [$];
    int          beat_cnt  = 0;
    int          done_cnt  = 0;
    int          av_cnt    = 0;
    int          hold_viol = 0;
    int          req_viol  = 0;
    logic        prev_iv = 1'b0, prev_ir = 1'b0, prev_av = 1'b0, prev_ar = 1'b0;
    logic [63:0] prev_ins = '0;
    logic [39:0] prev_req = '0;

    always #5 clk = ~clk;

    ins_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .ins_num        (ins_num),
        .busy           (busy),
        .done           (done),
        .ddr_addr       (ddr_addr),
        .ddr_size       (ddr_size),
        .ddr_addr_valid (ddr_addr_valid),
        .ddr_addr_ready (ddr_addr_ready),
        .ddr_data       (ddr_data),
        .ddr_valid      (ddr_valid),
        .ddr_ready      (ddr_ready),
        .ins            (ins),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .working        (working)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word k of the beat at byte address a holds instruction index a/8 + k.
    function automatic logic [511:0] mk_beat(input logic [31:0] a);
        logic [511:0] b;
        for (int k = 0; k < 8; k++) b[k*64 +: 64] = 64'(a / 8) + 64'(k);
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            if (ins_valid && ins_ready) ins_log.push_back(ins);
            if (ddr_addr_valid && ddr_addr_ready) req_log.push_back({ddr_addr, ddr_size});
            if (ddr_valid && ddr_ready) beat_cnt <= beat_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (ddr_addr_valid) av_cnt <= av_cnt + 1;
            if (prev_iv && !prev_ir && (!ins_valid || ins !== prev_ins)) hold_viol <= hold_viol + 1;
            if (prev_av && !prev_ar && (!ddr_addr_valid || {ddr_addr, ddr_size} !== prev_req))
                req_viol <= req_viol + 1;
            prev_iv  <= ins_valid;
            prev_ir  <= ins_ready;
            prev_ins <= ins;
            prev_av  <= ddr_addr_valid;
            prev_ar  <= ddr_addr_ready;
            prev_req <= {ddr_addr, ddr_size};
        end else begin
            prev_iv <= 1'b0;
            prev_av <= 1'b0;
        end
    end

    // DDR responder: one-cycle address ready delay, then back-to-back beats.
    initial begin : ddr_model
        logic        req_act;
        logic        waited;
        logic        prev_rdy;
        int          beats_rem;
        logic [31:0] baddr;
        logic [31:0] snap_addr;
        logic [7:0]  snap_size;
        req_act = 1'b0; waited = 1'b0; prev_rdy = 1'b0; beats_rem = 0;
        baddr = '0; snap_addr = '0; snap_size = '0;
        ddr_valid = 1'b0; ddr_addr_ready = 1'b0; ddr_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ddr_valid = 1'b0; ddr_addr_ready = 1'b0;
                req_act = 1'b0; waited = 1'b0; prev_rdy = 1'b0;
            end else begin
                if (req_act) begin
                    if (ddr_valid && prev_rdy) begin
                        beats_rem--;
                        baddr += 32'd64;
                    end
                    if (beats_rem == 0) begin
                        req_act = 1'b0;
                        ddr_valid = 1'b0;
                    end else begin
                        ddr_valid = 1'b1;
                        ddr_data = mk_beat(baddr);
                    end
                end else if (ddr_addr_ready) begin
                    ddr_addr_ready = 1'b0;
                    req_act = 1'b1;
                    waited = 1'b0;
                    beats_rem = int'(snap_size) + 1;
                    baddr = snap_addr;
                    ddr_valid = 1'b1;
                    ddr_data = mk_beat(baddr);
                end else if (ddr_addr_valid) begin
                    if (!waited) begin
                        snap_addr = ddr_addr;
                        snap_size = ddr_size;
                        waited = 1'b1;
                    end else begin
                        ddr_addr_ready = 1'b1;
                    end
                end
                prev_rdy = ddr_ready;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
        start = 1'b1; start_addr = a; ins_num = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ins(input string tag, input int target, input int budget);
        int n = 0;
        while (ins_log.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_arrive"}, 64'(ins_log.size() >= target), 64'd1);
    endtask

    // Holds working high a while, checks no early done, drops it and times done.
    task automatic finish_job(input string tag, input int db);
        int lat = 0;
        repeat (4) @(negedge clk);
        check_eq({tag, "_no_early_done"}, 64'(done_cnt), 64'(db));
        working = 1'b0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_done_lat"}, 64'(lat >= 1 && lat <= 2), 64'd1);
        check_eq({tag, "_busy_low"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_eq({tag, "_one_done"}, 64'(done_cnt), 64'(db + 1));
    endtask

    task automatic check_stream(input string tag, input int base, input logic [31:0] addr, input int num);
        int bad = 0;
        int have;
        have = ins_log.size() - base;
        check_eq({tag, "_count"}, 64'(have), 64'(num));
        for (int i = 0; i < num && i < have; i++)
            if (ins_log[base + i] !== 64'(addr / 8) + 64'(i)) bad++;
        check_eq({tag, "_order"}, 64'(bad), 64'd0);
    endtask

    initial begin : main
        int ib, rb, bb, db, ab, lat, n;
        rst = 1'b0; start = 1'b0; start_addr = '0; ins_num = '0;
        ins_ready = 1'b1; working = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_done",  64'(done), 64'd0);
        check_eq("rst_av",    64'(ddr_addr_valid), 64'd0);
        check_eq("rst_dready",64'(ddr_ready), 64'd0);
        check_eq("rst_ivld",  64'(ins_valid), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 20 instructions: one 3-beat burst, tail of last beat dropped
        ib = ins_log.size(); rb = req_log.size(); db = done_cnt;
        working = 1'b1;
        pulse_start(32'h1000, 16'd20);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_ins("t1", ib + 20, 400);
        finish_job("t1", db);
        check_stream("t1", ib, 32'h1000, 20);
        check_eq("t1_nreq", 64'(req_log.size() - rb), 64'd1);
        if (req_log.size() > rb) check_eq("t1_req0", 64'(req_log[rb]), {24'd0, 32'h1000, 8'd2});

        // 300 instructions: 38 beats in three bursts
        ib = ins_log.size(); rb = req_log.size(); bb = beat_cnt; db = done_cnt;
        working = 1'b1;
        pulse_start(32'h0, 16'd300);
        wait_ins("t2", ib + 300, 2000);
        finish_job("t2", db);
        check_stream("t2", ib, 32'h0, 300);
        check_eq("t2_beats", 64'(beat_cnt - bb), 64'd38);
        check_eq("t2_nreq", 64'(req_log.size() - rb), 64'd3);
        if (req_log.size() >= rb + 3) begin
            check_eq("t2_req0", 64'(req_log[rb]),     {24'd0, 32'h000, 8'd15});
            check_eq("t2_req1", 64'(req_log[rb + 1]), {24'd0, 32'h400, 8'd15});
            check_eq("t2_req2", 64'(req_log[rb + 2]), {24'd0, 32'h800, 8'd5});
        end

        // Consumer stalled 200 cycles: only the first burst may be fetched
        ib = ins_log.size(); rb = req_log.size(); bb = beat_cnt; db = done_cnt;
        ins_ready = 1'b0; working = 1'b1;
        pulse_start(32'h0, 16'd300);
        repeat (200) @(negedge clk);
        check_eq("t3_stall_nins",  64'(ins_log.size() - ib), 64'd0);
        check_eq("t3_stall_nreq",  64'(req_log.size() - rb), 64'd1);
        check_eq("t3_stall_beats", 64'(beat_cnt - bb), 64'd16);
        check_eq("t3_stall_av",    64'(ddr_addr_valid), 64'd0);
        check_eq("t3_stall_ivld",  64'(ins_valid), 64'd1);
        ins_ready = 1'b1;
        wait_ins("t3", ib + 300, 2000);
        finish_job("t3", db);
        check_stream("t3", ib, 32'h0, 300);
        check_eq("t3_beats", 64'(beat_cnt - bb), 64'd38);

        // Zero instructions: no DDR traffic, busy then done
        rb = req_log.size(); ab = av_cnt; db = done_cnt;
        pulse_start(32'h4000, 16'd0);
        check_eq("t4_busy", 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t4_done_lat", 64'(lat <= 3), 64'd1);
        repeat (2) @(negedge clk);
        check_eq("t4_no_av", 64'(av_cnt - ab), 64'd0);
        check_eq("t4_one_done", 64'(done_cnt), 64'(db + 1));

        // Second start while busy must be ignored
        ib = ins_log.size(); rb = req_log.size(); db = done_cnt;
        working = 1'b1;
        pulse_start(32'h3000, 16'd12);
        @(negedge clk);
        pulse_start(32'h5000, 16'd5);
        wait_ins("t5", ib + 12, 400);
        finish_job("t5", db);
        check_stream("t5", ib, 32'h3000, 12);
        check_eq("t5_nreq", 64'(req_log.size() - rb), 64'd1);
        if (req_log.size() > rb) check_eq("t5_req0", 64'(req_log[rb]), {24'd0, 32'h3000, 8'd1});

        // Reset in the middle of a burst, then a clean 8-instruction job
        bb = beat_cnt;
        working = 1'b1;
        pulse_start(32'h0, 16'd300);
        n = 0;
        while (beat_cnt < bb + 7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reach_beat7", 64'(beat_cnt - bb), 64'd7);
        rst = 1'b0; working = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_busy",  64'(busy), 64'd0);
        check_eq("t6_rst_done",  64'(done), 64'd0);
        check_eq("t6_rst_av",    64'(ddr_addr_valid), 64'd0);
        check_eq("t6_rst_dready",64'(ddr_ready), 64'd0);
        check_eq("t6_rst_ivld",  64'(ins_valid), 64'd0);
        check_eq("t6_rst_addr",  64'(ddr_addr), 64'd0);
        check_eq("t6_rst_size",  64'(ddr_size), 64'd0);
        check_eq("t6_rst_ins",   ins, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bb = beat_cnt;
        repeat (3) @(negedge clk);
        check_eq("t6_idle_dready", 64'(ddr_ready), 64'd0);
        check_eq("t6_idle_beats",  64'(beat_cnt - bb), 64'd0);
        ib = ins_log.size(); rb = req_log.size(); db = done_cnt;
        working = 1'b1;
        pulse_start(32'h2000, 16'd8);
        wait_ins("t6", ib + 8, 400);
        finish_job("t6", db);
        check_stream("t6", ib, 32'h2000, 8);
        check_eq("t6_nreq", 64'(req_log.size() - rb), 64'd1);
        if (req_log.size() > rb) check_eq("t6_req0", 64'(req_log[rb]), {24'd0, 32'h2000, 8'd0});

        check_eq("ins_hold_stable", 64'(hold_viol), 64'd0);
        check_eq("req_hold_stable", 64'(req_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
